// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// The result encoding is one-hot {lt, eq, gt}.
package serial_cmp_pkg;

  typedef enum logic [2:0] {
    CMP_NONE = 3'b000,
    CMP_GT   = 3'b001,
    CMP_EQ   = 3'b010,
    CMP_LT   = 3'b100
  } cmp_res_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Relation decided by a differing bit pair; inv flips it for a two's-complement sign bit.
  function automatic cmp_res_e bit_rel(input logic a, input logic inv);
    return (a ^ inv) ? CMP_GT : CMP_LT;
  endfunction

endpackage

// File: rtl/serial_cmp_n_frame_bit_cnt.sv
// Frame bit position counter: clr restarts the frame count.
// clr together with inc counts the current bit as bit 0.
module frame_bit_cnt #(
  parameter  int WIDTH = 32'd3,
  localparam int CW    = (WIDTH > 32'd1) ? $clog2(WIDTH) : 32'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] ONE      = CW'(1'b1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 32'd1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;

  // Next count: optional clear, then optional increment.
  always_comb begin
    count_next_s = count_r;
    if (clr) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r;
    end
    if (inc) begin
      count_next_s = count_next_s + ONE;
    end else begin
      count_next_s = count_next_s;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;
  assign last  = (count_r == LAST_IDX);

endmodule

// File: rtl/serial_cmp_n.sv
// Bit-serial WIDTH-bit magnitude comparator with framed input, stall,
// restart/abort and per-frame signed mode; registered one-hot result.
module serial_cmp_n
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = 32'd3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_vld,
  input  logic a,
  input  logic b,
  input  logic sgn,
  output logic lt,
  output logic eq,
  output logic gt,
  output logic res_vld,
  output logic busy,
  output logic aborted
);

  localparam int CW = (WIDTH > 32'd1) ? $clog2(WIDTH) : 32'd1;

  state_e   state_r, state_next_s;
  cmp_res_e rel_r, rel_cur_s, rel_next_s, res_r;
  logic     sgn_r, sgn_eff_s;
  logic     res_vld_r, aborted_r;
  logic     frame_start_s, accept_s, is_last_s, bit0_s, last_s;
  logic     clr_s, inc_s;
  logic [CW-1:0] count_s;

  frame_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .inc   (inc_s),
    .count (count_s),
    .last  (last_s)
  );

  // Acceptance qualification and the position of the bit being accepted.
  always_comb begin
    frame_start_s = bit_vld & start;
    accept_s      = bit_vld & (start | (state_r == SHIFT));
    is_last_s     = frame_start_s ? (WIDTH == 32'd1) : last_s;
    bit0_s        = frame_start_s ? 1'b1 : (count_s == {CW{1'b0}});
    sgn_eff_s     = frame_start_s ? sgn : sgn_r;
    rel_cur_s     = frame_start_s ? CMP_EQ : rel_r;
    clr_s         = frame_start_s | (accept_s & is_last_s);
    inc_s         = accept_s & ~is_last_s;
  end

  // Relation after the current bit; only the sign bit is inverted in signed mode.
  always_comb begin
    rel_next_s = rel_cur_s;
    if (a != b) begin
      if (MSB_FIRST) begin
        if (rel_cur_s == CMP_EQ) begin
          rel_next_s = bit_rel(a, bit0_s & sgn_eff_s);
        end else begin
          rel_next_s = rel_cur_s;
        end
      end else begin
        rel_next_s = bit_rel(a, is_last_s & sgn_eff_s);
      end
    end else begin
      rel_next_s = rel_cur_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (accept_s) begin
      state_next_s = is_last_s ? IDLE : SHIFT;
    end else begin
      state_next_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Running relation, latched sign mode, result and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_r     <= CMP_EQ;
      sgn_r     <= 1'b0;
      res_r     <= CMP_NONE;
      res_vld_r <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      if (accept_s) begin
        rel_r <= is_last_s ? CMP_EQ : rel_next_s;
      end
      if (frame_start_s) begin
        sgn_r <= sgn;
      end
      if (accept_s && is_last_s) begin
        res_r <= rel_next_s;
      end
      res_vld_r <= accept_s & is_last_s;
      aborted_r <= frame_start_s & (state_r == SHIFT);
    end
  end

  assign {lt, eq, gt} = res_r;
  assign res_vld      = res_vld_r;
  assign aborted      = aborted_r;
  assign busy         = (state_r == SHIFT);

endmodule

// File: doc/serial_cmp_n.md
Name: serial_cmp_n

Overview:
Parametrised bit-serial magnitude comparator, the successor of the 3-bit LSB-first comparator FSM. It compares two WIDTH-bit operands that arrive one bit per accepted cycle on a and b, and produces a registered one-hot {lt, eq, gt} result with a valid pulse. Frames are explicit and marked by start. Valid is gated per bit, and signed/unsigned mode is selectable per frame. Bit order is fixed at build time. The block sits between serial-link receivers and control logic that needs per-word ordering decisions.

Parameters:
WIDTH, 3, operand width in bits (>=1)
MSB_FIRST, 0, 0 = bits arrive LSB first, 1 = bits arrive MSB first

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  marks first bit of a frame; qualified by bit_vld
bit_vld  input  1  a/b carry a valid bit this cycle
a  input  1  serial bit of operand A
b  input  1  serial bit of operand B
sgn  input  1  two's-complement mode; sampled with the start bit, held for the frame
lt  output  1  A<B for last completed frame
eq  output  1  A==B for last completed frame
gt  output  1  A>B for last completed frame
res_vld  output  1  one-cycle pulse: lt/eq/gt just updated
busy  output  1  frame in progress
aborted  output  1  one-cycle pulse: frame dropped by a restart

Behaviour:
- Reset (async, rst_n=0): state IDLE; {lt,eq,gt}=000; res_vld=0; busy=0; aborted=0; bit count=0; running relation=EQ. Reset mid-frame discards the frame with no res_vld.
- Accepted bit = clock edge with bit_vld=1 while (IDLE and start=1) or SHIFT. In IDLE, bit_vld without start is ignored. start without bit_vld is ignored in every state.
- States:
  - IDLE -> SHIFT on the start bit. The start bit is frame bit 0; sgn is latched here.
  - SHIFT -> IDLE on acceptance of bit WIDTH-1.
  - With WIDTH=1, the start bit completes the frame, and the state stays IDLE.
- bit_vld=0 in SHIFT stalls the frame. Count and relation are held, and there is no timeout.
- start=1 with bit_vld=1 in SHIFT aborts the frame. aborted pulses next cycle, outputs keep the old result, and the current bit begins a new frame (new sgn latched).
- Relation update, LSB-first:
  - Equal bits keep the relation.
  - Differing bits set the relation to GT if a=1, else LT.
  - On the last bit (MSB) with sgn=1 and differing bits, the result is inverted: a=1 means LT.
- Relation update, MSB-first:
  - The first differing bit decides, and later bits are ignored.
  - If that first differing bit is bit 0 of the frame (MSB) and sgn=1, the result is inverted.
- Latency: the edge accepting the last bit registers {lt,eq,gt} and sets res_vld=1 for exactly one cycle. The result is visible the cycle after the last bit.
- {lt,eq,gt} is always one-hot after the first completed frame and holds until the next completed frame.
- busy=1 exactly while in SHIFT.
- Back-to-back: start may accompany the bit following the last bit. There are no idle cycles between frames.
- Bit counter width is $clog2(WIDTH) (minimum 1). It never exceeds WIDTH-1 and clears on frame completion, abort and reset.

Decomposition:
- Package serial_cmp_pkg:
  - typedef enum logic [2:0] cmp_res_e: CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001, CMP_NONE=3'b000. Bit order is {lt,eq,gt}.
  - typedef enum logic state_e {IDLE, SHIFT}.
- One sub-module: frame_bit_cnt (parametrised by WIDTH). Inputs clk, rst_n, clr, inc; outputs count, last (count==WIDTH-1).

Test Plan:
- WIDTH=3, LSB-first, sgn=0; A=5 (a: 1,0,1), B=3 (b: 1,1,0), bit_vld continuous -> cycle after 3rd bit: {lt,eq,gt}=001, res_vld one cycle.
- Same frame with sgn=1 (-3 vs 3) -> 100. A=6, B=6 unsigned -> 010.
- Stall: A=2, B=4 with bit_vld low 2 cycles after bit 1 -> busy stays 1, res_vld 2 cycles later than unstalled, result 100.
- Abort: 2 bits of A=1/B=0, then start with a new frame A=7, B=7 -> aborted pulse and no res_vld for the first frame. The next res_vld gives 010, and the prior result is held meanwhile.
- Reset asserted mid-frame, then released -> outputs 000, busy=0, no res_vld. The next full frame A=0, B=1 gives 100.
- WIDTH=8, MSB_FIRST=1: A=0x80, B=0x7F -> unsigned 001, signed 100. Back-to-back frames produce res_vld on consecutive 8-cycle boundaries.
